bcd_reaction_counter: RTL and testbench

Parametrised successor to the reaction-timer delay counter. It times a programmable wait phase and then measures the reaction interval as an N-digit BCD count with a configurable tick prescaler. It detects early presses (stop during the wait) and long delays (BCD overflow). It sits between the control FSM / button synchroniser and the 7-segment display driver.

---
 rtl/bcd_reaction_counter_pkg.sv | 21 ++
 rtl/bcd_reaction_counter_digit.sv | 28 ++
 rtl/bcd_reaction_counter.sv | 130 +++++++++++++
 tb/tb_bcd_reaction_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_reaction_counter_pkg.sv
// Shared types and helpers for the BCD reaction counter.
package rt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    TIME,
    HOLD,
    ERR_EARLY,
    ERR_LONG
  } rt_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Prescaler width; never zero so TICK_DIV=1 still yields a legal vector.
  function automatic int presc_width(input int div);
    if (div <= 1) return 1;
    return $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_reaction_counter_digit.sv
// One BCD digit (0..9) with synchronous clear and ripple carry.
module bcd_digit_cnt
  import rt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       carry_in,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       all_nine
);

  assign all_nine  = (q == BCD_MAX);
  assign carry_out = carry_in & all_nine;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc && carry_in) begin
      q <= all_nine ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_reaction_counter.sv
// Reaction timer: programmable wait phase followed by an N-digit BCD interval count.
//
// state     | meaning
// IDLE      | cleared, waiting for record_wait
// WAIT      | counting WAIT_TICKS ticks; stop here is an early press
// TIME      | BCD count advancing one step per tick
// HOLD      | user pressed stop, count frozen
// ERR_EARLY | stop seen during WAIT, count stays 0
// ERR_LONG  | count saturated at all 9s
module bcd_reaction_counter
  import rt_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int TICK_DIV   = 100000,
  parameter int WAIT_TICKS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  time_clr,
  input  logic                  record_wait,
  input  logic                  stop,
  output logic [4*N_DIGITS-1:0] digits,
  output logic                  record_wait_done,
  output logic                  error_long_delay,
  output logic                  error_early,
  output logic                  running
);

  localparam int PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_TICKS - 1);

  rt_state_t state;
  logic [PW-1:0] presc;
  logic [15:0] wait_cnt;
  logic tick;
  logic all_nine_all;
  logic cnt_clr;
  logic cnt_inc;
  logic [N_DIGITS-1:0] dig_nine;
  logic [N_DIGITS:0] carry;

  assign tick         = ((state == WAIT) || (state == TIME)) && (presc == PRESC_LAST);
  assign all_nine_all = &dig_nine;
  assign cnt_clr      = time_clr || (state == IDLE);
  // carry out of the top digit means this increment would wrap; block it to saturate.
  assign cnt_inc      = (state == TIME) && !time_clr && !stop && tick && !carry[N_DIGITS];
  assign carry[0]     = 1'b1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit_cnt u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .carry_in (carry[g]),
      .q        (digits[4*g +: 4]),
      .carry_out(carry[g+1]),
      .all_nine (dig_nine[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      presc            <= '0;
      wait_cnt         <= 16'd0;
      record_wait_done <= 1'b0;
      error_long_delay <= 1'b0;
      error_early      <= 1'b0;
      running          <= 1'b0;
    end else begin
      record_wait_done <= 1'b0;
      if (tick || !((state == WAIT) || (state == TIME))) presc <= '0;
      else                                              presc <= presc + 1'b1;

      if (time_clr) begin
        state            <= IDLE;
        presc            <= '0;
        wait_cnt         <= 16'd0;
        error_long_delay <= 1'b0;
        error_early      <= 1'b0;
        running          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            wait_cnt <= 16'd0;
            if (record_wait) begin
              state <= WAIT;
              presc <= '0;
            end
          end
          WAIT: begin
            if (stop) begin
              state       <= ERR_EARLY;
              error_early <= 1'b1;
              presc       <= '0;
            end else if (!record_wait) begin
              state    <= IDLE;
              wait_cnt <= 16'd0;
              presc    <= '0;
            end else if (tick) begin
              if (wait_cnt == WAIT_LAST) begin
                state            <= TIME;
                record_wait_done <= 1'b1;
                running          <= 1'b1;
                wait_cnt         <= 16'd0;
              end else begin
                wait_cnt <= wait_cnt + 16'd1;
              end
            end
          end
          TIME: begin
            if (stop) begin
              state   <= HOLD;
              running <= 1'b0;
              presc   <= '0;
            end else if (tick && all_nine_all) begin
              state            <= ERR_LONG;
              error_long_delay <= 1'b1;
              running          <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_reaction_counter.sv
// Scoreboard bench for two configurations of bcd_reaction_counter sharing one stimulus stream.
module tb_bcd_reaction_counter;

  localparam int P_IDLE = 0, P_WAIT = 1, P_TIME = 2, P_HOLD = 3, P_EARLY = 4, P_LONG = 5;

  logic clk = 1'b0;
  logic rst, time_clr, record_wait, stop;
  logic [15:0] dig_a;
  logic [7:0]  dig_b;
  logic done_a, elong_a, eearly_a, run_a;
  logic done_b, elong_b, eearly_b, run_b;

  always #5 clk = ~clk;

  bcd_reaction_counter #(.N_DIGITS(4), .TICK_DIV(1), .WAIT_TICKS(5)) dut_a (
    .clk(clk), .rst(rst), .time_clr(time_clr), .record_wait(record_wait), .stop(stop),
    .digits(dig_a), .record_wait_done(done_a), .error_long_delay(elong_a),
    .error_early(eearly_a), .running(run_a));

  bcd_reaction_counter #(.N_DIGITS(2), .TICK_DIV(4), .WAIT_TICKS(3)) dut_b (
    .clk(clk), .rst(rst), .time_clr(time_clr), .record_wait(record_wait), .stop(stop),
    .digits(dig_b), .record_wait_done(done_b), .error_long_delay(elong_b),
    .error_early(eearly_b), .running(run_b));

  typedef struct packed {
    logic [15:0] d;
    logic        done;
    logic        elong;
    logic        eearly;
    logic        run;
  } obs_t;

  obs_t sb_a[$];
  obs_t sb_b[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: elapsed-cycle arithmetic and an integer count, converted to BCD on output.
  int div_c[2] = '{1, 4};
  int wt_c[2]  = '{5, 3};
  int max_c[2] = '{9999, 99};
  int phase[2], elapsed[2], count[2];
  bit done_f[2], long_f[2], early_f[2];

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset(input int i);
    phase[i] = P_IDLE; elapsed[i] = 0; count[i] = 0;
    done_f[i] = 0; long_f[i] = 0; early_f[i] = 0;
  endtask

  task automatic model_step(input int i);
    done_f[i] = 0;
    if (rst || time_clr) begin
      model_reset(i);
    end else begin
      case (phase[i])
        P_IDLE: if (record_wait) begin phase[i] = P_WAIT; elapsed[i] = 0; end
        P_WAIT: begin
          elapsed[i]++;
          if (stop) begin phase[i] = P_EARLY; early_f[i] = 1; end
          else if (!record_wait) phase[i] = P_IDLE;
          else if (elapsed[i] == wt_c[i] * div_c[i]) begin
            phase[i] = P_TIME; done_f[i] = 1; elapsed[i] = 0;
          end
        end
        P_TIME: begin
          elapsed[i]++;
          if (stop) phase[i] = P_HOLD;
          else if (elapsed[i] % div_c[i] == 0) begin
            if (count[i] == max_c[i]) begin phase[i] = P_LONG; long_f[i] = 1; end
            else count[i]++;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic obs_t expect_of(input int i);
    obs_t o;
    logic [31:0] b;
    b = to_bcd(count[i]);
    o.d = b[15:0];
    o.done = done_f[i];
    o.elong = long_f[i];
    o.eearly = early_f[i];
    o.run = (phase[i] == P_TIME);
    return o;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    sb_a.push_back(expect_of(0));
    sb_b.push_back(expect_of(1));
    #1;
  endtask

  task automatic bound_check(input string name, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: cycle budget expired before expected condition was reached", name);
    end
  endtask

  // Asserts rst between edges; both counters must clear without a clock edge.
  task automatic async_rst_check();
    #2;
    sb_a.delete();
    sb_b.delete();
    rst = 1'b1;
    #1;
    n_cmp += 2;
    if (dig_a !== 16'h0000) begin
      n_bad++;
      $display("FAIL async_rst_a: got digits=%h required 0000", dig_a);
    end
    if (dig_b !== 8'h00) begin
      n_bad++;
      $display("FAIL async_rst_b: got digits=%h required 00", dig_b);
    end
  endtask

  obs_t exp_o, got_o;
  always @(negedge clk) begin
    if (sb_a.size() > 0) begin
      exp_o = sb_a.pop_front();
      got_o = {dig_a, done_a, elong_a, eearly_a, run_a};
      n_cmp++;
      if (got_o !== exp_o) begin
        n_bad++;
        $display("FAIL out_a @%0t: got d=%h done/elong/eearly/run=%b required d=%h %b",
                 $time, got_o.d, got_o[3:0], exp_o.d, exp_o[3:0]);
      end
    end
    if (sb_b.size() > 0) begin
      exp_o = sb_b.pop_front();
      got_o = {8'h00, dig_b, done_b, elong_b, eearly_b, run_b};
      n_cmp++;
      if (got_o !== exp_o) begin
        n_bad++;
        $display("FAIL out_b @%0t: got d=%h done/elong/eearly/run=%b required d=%h %b",
                 $time, got_o.d, got_o[3:0], exp_o.d, exp_o[3:0]);
      end
    end
  end

  initial begin
    int k;
    model_reset(0);
    model_reset(1);
    rst = 1'b1;
    time_clr = 1'($urandom);
    record_wait = 1'($urandom);
    stop = 1'($urandom);
    repeat (3) begin
      cycle();
      time_clr = 1'($urandom); record_wait = 1'($urandom); stop = 1'($urandom);
    end
    rst = 1'b0; time_clr = 1'b0; record_wait = 1'b0; stop = 1'b0;
    cycle();

    // Wait phase, timing, then stop at 12 and hold.
    record_wait = 1'b1;
    k = 0;
    while (count[0] != 12 && k < 100) begin cycle(); k++; end
    bound_check("reach_12", count[0] == 12);
    stop = 1'b1;
    repeat (20) cycle();
    stop = 1'b0; time_clr = 1'b1;
    cycle();
    time_clr = 1'b0; record_wait = 1'b0;
    cycle();

    // Early press on the third wait tick.
    record_wait = 1'b1;
    repeat (3) cycle();
    stop = 1'b1;
    cycle();
    repeat (10) begin
      stop = 1'($urandom); record_wait = 1'($urandom);
      cycle();
    end
    stop = 1'b0; time_clr = 1'b1;
    cycle();
    time_clr = 1'b0; record_wait = 1'b0;
    cycle();

    // Long delay: saturate at all 9s.
    record_wait = 1'b1;
    k = 0;
    while (!long_f[0] && k < 10100) begin cycle(); k++; end
    bound_check("reach_long", long_f[0] == 1'b1);
    repeat (5) cycle();
    time_clr = 1'b1;
    cycle();
    time_clr = 1'b0; record_wait = 1'b0;
    cycle();

    // Prescaler phase restore after time_clr, then async reset mid-TIME.
    record_wait = 1'b1;
    k = 0;
    while (!(phase[1] == P_TIME && elapsed[1] == 2) && k < 100) begin cycle(); k++; end
    bound_check("reach_time_b", phase[1] == P_TIME);
    time_clr = 1'b1;
    cycle();
    time_clr = 1'b0;
    repeat (40) cycle();
    async_rst_check();
    cycle();
    cycle();
    rst = 1'b0; record_wait = 1'b0;
    cycle();

    // Randomized traffic.
    repeat (600) begin
      record_wait = ($urandom_range(0, 9) != 0);
      stop        = ($urandom_range(0, 29) == 0);
      time_clr    = ($urandom_range(0, 59) == 0);
      cycle();
    end
    record_wait = 1'b0; stop = 1'b0; time_clr = 1'b0;
    cycle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
